tube_arbiter: RTL and testbench

Sequencer and two-way arbiter for the Tube parasite interface. It converts word-level read/write requests into correctly phased Tube bus cycles (CS*, PHI2, RnW*, address, data). There are two requesters: the host Z80 I/O path (H) and the on-CPLD Tube status poller (P), and the block grants them round-robin. It sits between the host decode logic and the top-level Tube pins; tristate resolution of TUBE_DATA stays in the top level.

---
 rtl/tube_arbiter.sv | 124 ++++++++++++
 tb/tb_tube_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tube_arbiter.sv
// Tube bus sequencer with round-robin arbitration between the host I/O path (H)
// and the status poller (P). Turns word requests into phased CS*/PHI2 bus cycles.
module tube_arbiter #(
    parameter int SETUP_CYC = 1,
    parameter int PHI2_CYC  = 2
) (
    input  logic       CLK,
    input  logic       RESET_B,
    input  logic       h_req,
    input  logic       h_rnw,
    input  logic [2:0] h_adr,
    input  logic [7:0] h_wdata,
    output logic       h_ack,
    output logic [7:0] h_rdata,
    input  logic       p_req,
    input  logic       p_rnw,
    input  logic [2:0] p_adr,
    input  logic [7:0] p_wdata,
    output logic       p_ack,
    output logic [7:0] p_rdata,
    output logic       TUBE_CS_B,
    output logic       TUBE_PHI2,
    output logic [2:0] TUBE_ADR,
    output logic       TUBE_RNW_B,
    output logic [7:0] tube_dout,
    output logic       tube_doe,
    input  logic [7:0] tube_din,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;

    typedef struct packed {
        logic       rnw;
        logic [2:0] adr;
        logic [7:0] wdata;
    } tube_req_t;

    localparam logic [2:0] SETUP_LD = 3'(SETUP_CYC - 1);
    localparam logic [2:0] PHI2_LD  = 3'(PHI2_CYC - 1);

    state_t    state, state_d;
    logic [2:0] cnt, cnt_d;
    tube_req_t lat, lat_d;
    logic      gnt_p, gnt_p_d;   // current / most recent grant went to P
    logic      gap;              // first IDLE cycle after HOLD never grants

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        lat_d   = lat;
        gnt_p_d = gnt_p;
        case (state)
            IDLE: begin
                if (!gap && (h_req || p_req)) begin
                    gnt_p_d = p_req && (!h_req || !gnt_p);
                    lat_d   = gnt_p_d ? tube_req_t'{p_rnw, p_adr, p_wdata}
                                      : tube_req_t'{h_rnw, h_adr, h_wdata};
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 3'd0) begin
                    cnt_d   = PHI2_LD;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt - 3'd1;
                end
            end
            HIGH: begin
                if (cnt == 3'd0) state_d = HOLD;
                else             cnt_d   = cnt - 3'd1;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            lat        <= '0;
            gnt_p      <= 1'b1;
            gap        <= 1'b0;
            TUBE_CS_B  <= 1'b1;
            TUBE_PHI2  <= 1'b0;
            TUBE_ADR   <= 3'd0;
            TUBE_RNW_B <= 1'b1;
            tube_dout  <= 8'd0;
            tube_doe   <= 1'b0;
            h_ack      <= 1'b0;
            p_ack      <= 1'b0;
            h_rdata    <= 8'd0;
            p_rdata    <= 8'd0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            lat        <= lat_d;
            gnt_p      <= gnt_p_d;
            gap        <= (state == HOLD);
            TUBE_CS_B  <= (state_d == IDLE);
            TUBE_PHI2  <= (state_d == HIGH);
            TUBE_RNW_B <= (state_d == IDLE) || lat_d.rnw;
            tube_doe   <= (state_d == HIGH || state_d == HOLD) && !lat_d.rnw;
            h_ack      <= (state_d == HOLD) && !gnt_p_d;
            p_ack      <= (state_d == HOLD) && gnt_p_d;
            busy       <= (state_d != IDLE);
            if (state_d != IDLE)
                TUBE_ADR <= lat_d.adr;
            if (state_d == HIGH && !lat_d.rnw)
                tube_dout <= lat_d.wdata;
            if (state == HIGH && state_d == HOLD && lat.rnw) begin
                if (gnt_p) p_rdata <= tube_din;
                else       h_rdata <= tube_din;
            end
        end
    end

endmodule

// File: tb/tb_tube_arbiter.sv
// Directed bench for tube_arbiter: ack scoreboard plus per-cycle pin checks,
// with a second instance for a non-default phase-length configuration.
module tb_tube_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_B;
    logic       h_req, h_rnw, p_req, p_rnw;
    logic [2:0] h_adr, p_adr;
    logic [7:0] h_wdata, p_wdata, tube_din;
    logic       h_ack, p_ack, TUBE_CS_B, TUBE_PHI2, TUBE_RNW_B, tube_doe, busy;
    logic [7:0] h_rdata, p_rdata, tube_dout;
    logic [2:0] TUBE_ADR;

    logic       h_req2, p_req2;
    logic       h_ack2, p_ack2, cs_b2, phi2_2, rnw_b2, doe2, busy2;
    logic [7:0] h_rdata2, p_rdata2, dout2;
    logic [2:0] adr2;

    always #5 CLK = ~CLK;

    tube_arbiter dut (
        .CLK(CLK), .RESET_B(RESET_B),
        .h_req(h_req), .h_rnw(h_rnw), .h_adr(h_adr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata),
        .p_req(p_req), .p_rnw(p_rnw), .p_adr(p_adr), .p_wdata(p_wdata),
        .p_ack(p_ack), .p_rdata(p_rdata),
        .TUBE_CS_B(TUBE_CS_B), .TUBE_PHI2(TUBE_PHI2), .TUBE_ADR(TUBE_ADR),
        .TUBE_RNW_B(TUBE_RNW_B), .tube_dout(tube_dout), .tube_doe(tube_doe),
        .tube_din(tube_din), .busy(busy)
    );

    tube_arbiter #(.SETUP_CYC(3), .PHI2_CYC(1)) dut2 (
        .CLK(CLK), .RESET_B(RESET_B),
        .h_req(h_req2), .h_rnw(h_rnw), .h_adr(h_adr), .h_wdata(h_wdata),
        .h_ack(h_ack2), .h_rdata(h_rdata2),
        .p_req(p_req2), .p_rnw(p_rnw), .p_adr(p_adr), .p_wdata(p_wdata),
        .p_ack(p_ack2), .p_rdata(p_rdata2),
        .TUBE_CS_B(cs_b2), .TUBE_PHI2(phi2_2), .TUBE_ADR(adr2),
        .TUBE_RNW_B(rnw_b2), .tube_dout(dout2), .tube_doe(doe2),
        .tube_din(tube_din), .busy(busy2)
    );

    typedef struct {
        bit         p;
        bit         rd;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   t0;
    bit   h_drop = 1'b1;
    bit   p_drop = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit p, input bit rd, input logic [7:0] rdata, input int at);
        exp_t e;
        e.p = p; e.rd = rd; e.rdata = rdata; e.cyc = at;
        sbq.push_back(e);
    endtask

    // Advance one clock and sample; any ack on the default instance is
    // matched against the head of the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        if (h_ack || p_ack) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {30'd0, h_ack, p_ack}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("ack_who", {30'd0, h_ack, p_ack}, e.p ? 32'd1 : 32'd2);
                chk("ack_cycle", cyc - t0, e.cyc);
                if (e.rd) chk("ack_rdata", e.p ? p_rdata : h_rdata, e.rdata);
            end
            if (h_ack && h_drop) h_req = 1'b0;
            if (p_ack && p_drop) p_req = 1'b0;
        end
    endtask

    initial begin
        RESET_B = 1'b0;
        h_req = 0; h_rnw = 0; h_adr = 0; h_wdata = 0;
        p_req = 0; p_rnw = 0; p_adr = 0; p_wdata = 0;
        h_req2 = 0; p_req2 = 0; tube_din = 8'hA7;
        t0 = 0;
        tick(); tick();
        chk("rst_cs_b", TUBE_CS_B, 1);  chk("rst_phi2", TUBE_PHI2, 0);
        chk("rst_adr", TUBE_ADR, 0);    chk("rst_rnw_b", TUBE_RNW_B, 1);
        chk("rst_dout", tube_dout, 0);  chk("rst_doe", tube_doe, 0);
        chk("rst_acks", {h_ack, p_ack}, 0);
        chk("rst_rdata", {h_rdata, p_rdata}, 0);
        chk("rst_busy", busy, 0);       chk("rst2_cs_b", cs_b2, 1);
        RESET_B = 1'b1;
        tick();

        // Host read
        h_rnw = 1; h_adr = 3'd5; h_req = 1; t0 = cyc;
        push(0, 1, 8'hA7, 4);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("hrd_cs_b[%0d]", k), TUBE_CS_B, !(k >= 1 && k <= 4));
            chk($sformatf("hrd_phi2[%0d]", k), TUBE_PHI2, (k == 2 || k == 3));
            chk($sformatf("hrd_pack[%0d]", k), p_ack, 0);
            if (k == 1) begin
                chk("hrd_adr", TUBE_ADR, 5);
                chk("hrd_rnw_b", TUBE_RNW_B, 1);
                chk("hrd_busy", busy, 1);
            end
        end
        chk("hrd_idle_busy", busy, 0);
        tick();

        // Poller write
        p_rnw = 0; p_adr = 3'd1; p_wdata = 8'h3C; p_req = 1; t0 = cyc;
        push(1, 0, 8'h00, 4);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("pwr_rnw_b[%0d]", k), TUBE_RNW_B, !(k <= 4));
            chk($sformatf("pwr_adr[%0d]", k), TUBE_ADR, 1);
            chk($sformatf("pwr_doe[%0d]", k), tube_doe, (k >= 2 && k <= 4));
            if (k >= 2 && k <= 4) chk($sformatf("pwr_dout[%0d]", k), tube_dout, 8'h3C);
            chk($sformatf("pwr_hack[%0d]", k), h_ack, 0);
        end
        tick();

        // Tie after a P grant: H, P, H, P with acks six cycles apart
        h_drop = 0; p_drop = 0;
        h_rnw = 1; p_rnw = 1; h_req = 1; p_req = 1; t0 = cyc;
        push(0, 1, 8'hA7, 4);  push(1, 1, 8'hA7, 10);
        push(0, 1, 8'hA7, 16); push(1, 1, 8'hA7, 22);
        for (int k = 1; k <= 28; k++) begin
            tick();
            if (k == 12) begin h_drop = 1; p_drop = 1; end
        end
        chk("tie_sb_empty", sbq.size(), 0);
        chk("tie_reqs_dropped", {h_req, p_req}, 0);

        // Fields changed after grant must not reach the pins
        h_rnw = 0; h_adr = 3'd2; h_wdata = 8'h55; h_req = 1; t0 = cyc;
        push(0, 0, 8'h00, 4);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin h_adr = 3'd6; h_wdata = 8'hAA; end
            chk($sformatf("stale_adr[%0d]", k), TUBE_ADR, 2);
            if (k >= 2 && k <= 4) chk($sformatf("stale_dout[%0d]", k), tube_dout, 8'h55);
        end
        tick();

        // Asynchronous reset in the middle of HIGH during a host write
        h_adr = 3'd3; h_wdata = 8'h99; h_req = 1; t0 = cyc;
        tick(); tick();
        chk("rstmid_doe_before", tube_doe, 1);
        #2 RESET_B = 1'b0;
        #1;
        chk("rstmid_cs_b", TUBE_CS_B, 1); chk("rstmid_phi2", TUBE_PHI2, 0);
        chk("rstmid_doe", tube_doe, 0);   chk("rstmid_busy", busy, 0);
        h_req = 0;
        tick(); tick();
        RESET_B = 1'b1;
        tick();
        h_rnw = 1; h_adr = 3'd4; h_req = 1; t0 = cyc;
        push(0, 1, 8'hA7, 4);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("rstnew_cs_b[%0d]", k), TUBE_CS_B, !(k >= 1 && k <= 4));
        end
        chk("rst_sb_empty", sbq.size(), 0);
        tick();

        // SETUP_CYC=3, PHI2_CYC=1: read data sampled at the end of cycle 4
        tube_din = 8'h00; h_rnw = 1; h_adr = 3'd7; h_req2 = 1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("sw_phi2[%0d]", k), phi2_2, (k == 4));
            chk($sformatf("sw_cs_b[%0d]", k), cs_b2, !(k >= 1 && k <= 5));
            chk($sformatf("sw_ack[%0d]", k), h_ack2, (k == 5));
            if (k == 4) tube_din = 8'h5A;
            if (k == 5) begin
                chk("sw_rdata", h_rdata2, 8'h5A);
                h_req2 = 0;
            end
        end
        chk("sw_pack", p_ack2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
